// File: rtl/chart_player.sv
// chart_player: chart playback initiator.
//   Issues a one-cycle read request for a chart ID to the chart store and
//   captures the returned chart after RD_LATENCY cycles. It then steps
//   through the chart's notes, holding each note for STEP_CYCLES cycles, and
//   presents the current note to the display/audio/judge logic.
//
// Optional build macro: CHART_PLAYER_LOOP_EN
//   When defined, playback wraps from the last note back to note 0 with no gap.
//   done still pulses at every wrap. Only stop or reset ends playback.
//   When undefined, playback ends in IDLE after the last slot.
//
// Ports:
//   clk            system clock
//   sys_rst_n      asynchronous active-low reset
//   start          pulse, begin playback of chart_id
//   chart_id[7:0]  chart to play (1-based, 0 is invalid)
//   stop           pulse, abort playback
//   pause          level, freezes the step timer while high
//   read_chart_id  request to storage, non-zero for one cycle per request
//   chart_data     current chart from storage (info.note_cnt, notes[])
//   note_out[8:0]  current note bitmask, 0 when not playing
//   note_idx       index of the note being presented
//   note_valid     high while a note slot is presented (PLAY or PAUSE)
//   step_pulse     one-cycle pulse on the first cycle of each slot
//   busy           high in any state except IDLE
//   done           one-cycle pulse when the last slot ends
//   err            sticky, set by start with chart_id==0, cleared by a valid start
//
// States:
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_REQ   | read request presented to storage for one cycle
//   S_WAIT  | read latency countdown, chart captured on the final cycle
//   S_PLAY  | note presented, step timer running
//   S_PAUSE | note presented, entered because pause was high

package chart_pkg;
  localparam int MAX_NOTES = 8;

  typedef logic [8:0] notes_t;

  typedef struct packed {
    logic [7:0] note_cnt;
  } chart_info_t;

  typedef struct packed {
    chart_info_t                info;
    notes_t [MAX_NOTES-1:0]     notes;
  } chart_t;
endpackage

module chart_player
  import chart_pkg::*;
#(
  parameter int STEP_CYCLES = 5_000_000,
  parameter int RD_LATENCY  = 2,
  parameter int IDX_W       = 16
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [7:0]       chart_id,
  input  logic             stop,
  input  logic             pause,
  output logic [7:0]       read_chart_id,
  input  chart_t           chart_data,
  output logic [8:0]       note_out,
  output logic [IDX_W-1:0] note_idx,
  output logic             note_valid,
  output logic             step_pulse,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int SEL_W = $clog2(MAX_NOTES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PLAY, S_PAUSE} state_t;

  state_t                 state, state_d;
  logic [7:0]             id_q;
  logic [LAT_W-1:0]       lat_cnt;
  logic [TMR_W-1:0]       timer;
  logic [IDX_W-1:0]       idx;
  logic [7:0]             cnt_q;
  logic [7:0]             cnt_in;
  notes_t [MAX_NOTES-1:0] notes_q;
  logic                   fresh;
  logic                   empty_done;
  logic                   active;
  logic                   run;
  logic                   tc;
  logic                   last;

  // A note count larger than the notes array is clamped to the array size.
  assign cnt_in = (chart_data.info.note_cnt > 8'(MAX_NOTES)) ? 8'(MAX_NOTES)
                                                             : chart_data.info.note_cnt;

  assign active = (state == S_PLAY) || (state == S_PAUSE);
  // The slot timer advances on every playing cycle with pause low. This
  // includes the cycle spent in PAUSE after pause drops, so a pause costs
  // exactly as many cycles as pause was high.
  assign run    = active && !stop && !pause;
  // The timer counts down from STEP_CYCLES-1. Terminal count is zero.
  assign tc     = run && (timer == '0);
  assign last   = (32'(idx) + 32'd1) == 32'(cnt_q);

  assign busy     = (state != S_IDLE);
  assign note_idx = active ? idx : '0;

  always_comb begin
    state_d       = state;
    read_chart_id = '0;
    note_out      = '0;
    note_valid    = 1'b0;
    step_pulse    = 1'b0;
    done          = empty_done;
    case (state)
      S_IDLE: begin
        if (start && (chart_id != 8'd0)) state_d = S_REQ;
      end
      S_REQ: begin
        read_chart_id = id_q;
        state_d       = stop ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (lat_cnt == '0) begin
          state_d = (cnt_in == 8'd0) ? S_IDLE : S_PLAY;
        end
      end
      S_PLAY, S_PAUSE: begin
        note_out   = notes_q[idx[SEL_W-1:0]];
        note_valid = 1'b1;
        step_pulse = (state == S_PLAY) && fresh;
        if (stop) begin
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (tc && last) begin
          done = 1'b1;
`ifdef CHART_PLAYER_LOOP_EN
          state_d = S_PLAY;
`else
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      id_q       <= '0;
      lat_cnt    <= '0;
      timer      <= '0;
      idx        <= '0;
      cnt_q      <= '0;
      notes_q    <= '0;
      fresh      <= 1'b0;
      empty_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      empty_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (chart_id != 8'd0) begin
              id_q <= chart_id;
              err  <= 1'b0;
            end else begin
              err  <= 1'b1;
            end
          end
        end
        S_REQ: lat_cnt <= LAT_LOAD;
        S_WAIT: begin
          if (!stop) begin
            if (lat_cnt != '0) begin
              lat_cnt <= lat_cnt - 1'b1;
            end else begin
              cnt_q      <= cnt_in;
              notes_q    <= chart_data.notes;
              idx        <= '0;
              timer      <= TMR_LOAD;
              fresh      <= 1'b1;
              empty_done <= (cnt_in == 8'd0);
            end
          end
        end
        S_PLAY, S_PAUSE: begin
          if (state == S_PLAY) fresh <= 1'b0;
          if (run) begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else begin
              timer <= TMR_LOAD;
              fresh <= 1'b1;
              idx   <= last ? '0 : idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/chart_player.md
Name: chart_player

Overview:
- Playback initiator for the chart store: sends a one-cycle read request for a chart ID and captures the returned Chart.
- Then steps through the chart's notes at a fixed step rate and presents the current note to the display/audio/judge logic.
- Sits between the game-mode FSM (start/stop/pause) and the chart storage manager's read port.

Parameters:
- STEP_CYCLES, 5_000_000, clock cycles each note slot is held (one chart step).
- RD_LATENCY, 2, cycles from asserting read_chart_id to capturing chart_data; minimum 1.
- IDX_W, 16, width of the note index and step counters.

Ports:
- clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin playback of chart_id
- chart_id  in  8  chart to play, 1-based; 0 is invalid
- stop  in  1  pulse; abort playback
- pause  in  1  level; freezes the step timer while high
- read_chart_id  out  8  byte to storage; non-zero for exactly one cycle per request
- chart_data  in  Chart  current_chart_data from storage (info.note_cnt, notes[])
- note_out  out  9  current Notes bitmask; 0 when not playing
- note_idx  out  IDX_W  index of the note currently presented
- note_valid  out  1  high while a note slot is presented (PLAY or PAUSE)
- step_pulse  out  1  one-cycle pulse on the first cycle of each new note slot
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the last slot ends
- err  out  1  sticky; set when start arrives with chart_id==0; cleared by the next valid start

Behaviour:
- Reset: asynchronous, active-low.
  - State=IDLE.
  - All outputs 0; read_chart_id=0.
  - Internal chart register, counters and err cleared.
- IDLE:
  - start with chart_id!=0: go to REQ; clear err.
  - start with chart_id==0: set err, stay in IDLE.
  - stop: ignored.
- REQ (1 cycle):
  - read_chart_id=chart_id, sampled on the start cycle.
  - Go to WAIT; wait counter loaded with RD_LATENCY-1.
- WAIT:
  - read_chart_id=0.
  - Counter decrements to 0, then chart_data is captured into a local register.
  - If captured note_cnt==0: pulse done, go to IDLE.
  - Otherwise: note_idx=0, timer=0, go to PLAY.
- PLAY:
  - note_out=notes[note_idx]; note_valid=1.
  - step_pulse on the first cycle of every slot, including idx 0.
  - Timer counts 0..STEP_CYCLES-1.
  - At the terminal count with note_idx<note_cnt-1: note_idx++, timer=0.
  - At the terminal count with note_idx==note_cnt-1: pulse done in that cycle; next cycle goes to IDLE with note_out=0 and note_valid=0.
  - pause high: go to PAUSE, timer frozen.
- PAUSE:
  - note_out and note_idx held; note_valid=1; no step_pulse.
  - pause low: return to PLAY, timer resumes from its frozen value.
- stop:
  - In REQ/WAIT/PLAY/PAUSE: go to IDLE next cycle; note_out=0; no done pulse.
  - Priority: stop > pause > timer terminal count.
- start while busy: ignored. Restart requires stop then start.
- Simultaneous start and stop in IDLE: start wins (stop is ignored in IDLE).
- Latency: start to first note_out = 1 (REQ) + RD_LATENCY cycles.
  - Example: RD_LATENCY=2 gives note visible on the 4th edge after start.
- Each slot lasts exactly STEP_CYCLES cycles when not paused.
- note_cnt above the notes array size is clamped to the array size.
- Asynchronous reset mid-playback: immediate return to the reset values; no done pulse.

Optional Feature:
- Macro: CHART_PLAYER_LOOP_EN.
- Defined: at the end of the last slot, done still pulses; note_idx wraps to 0 and PLAY continues with no gap. Only stop or reset leaves playback.
- Undefined: playback ends in IDLE after the last slot, as specified above.

Test Plan:
- Basic run: STEP_CYCLES=4, RD_LATENCY=2, stub chart note_cnt=3, notes={C4,G4,NU}, start with chart_id=1 ->
  - read_chart_id=1 for 1 cycle;
  - note_out = 0x001 ×4, 0x010 ×4, 0x000 ×4 cycles;
  - 3 step_pulses; done at cycle 12 of playback; busy low afterwards.
- Empty chart: note_cnt=0, start with chart_id=2 -> done pulse immediately after the capture cycle; note_valid never high.
- Pause: assert pause for 10 cycles on cycle 2 of slot 1 -> note_out held at 0x010 during the pause; the slot ends 2 cycles after pause drops; total run = 12+10 cycles.
- Stop mid-play: stop during slot 1 -> IDLE next cycle; note_out=0; no done; a new start with chart_id=1 replays from idx 0.
- Invalid ID and ignored start: start with chart_id=0 -> err=1, busy=0, read_chart_id stays 0. A start pulse during PLAY -> no new read request.
- Async reset: drop sys_rst_n mid-slot, between clock edges -> all outputs 0 before the next edge. With CHART_PLAYER_LOOP_EN, the 3-note chart wraps idx 2 -> 0 with done pulsing at each wrap.
